knight_anim_seq: RTL and testbench
==================================

Name: knight_anim_seq

Overview:
- Sprite animation sequencer directly downstream of the player movement block.
- Consumes the player's 4-bit status code and facing bit each frame_clk, and produces the sprite sheet row, frame index and flip control for the knight sprite ROM address generator.
- Also produces the attack hit window for the collision and damage logic.
- Owns animation timing: per-state frame counts, looping versus one-shot versus hold-last, and attack latching so a short attack keypress still plays the full swing.

Parameters:
- TICKS_PER_FRAME, 6, frame_clk cycles each animation frame is displayed (1..15)
- IDLE_FRAMES, 4, frames in idle loop (1..8)
- WALK_FRAMES, 6, frames in walk loop (1..8)
- JUMP_FRAMES, 3, frames in jump-up sequence; holds last frame (1..8)
- FALL_FRAMES, 2, frames in fall loop (1..8)
- ATK_FRAMES, 5, frames in attack one-shot (1..8)
- DEAD_FRAMES, 6, frames in death one-shot; holds last frame (1..8)
- ATK_HIT_FIRST, 2, first attack frame with hitbox active
- ATK_HIT_LAST, 3, last attack frame with hitbox active

Ports:
- frame_clk  in  1  sole clock, one pulse per video frame
- Reset  in  1  asynchronous, active-high reset
- Player_Status  in  4  0 idle, 1 walk, 2 jump up, 3 fall, 4 attack, 5 dead; 6..15 invalid
- Inverse  in  1  facing: 0 right, 1 left
- Anim_Row  out  3  sprite sheet row, same encoding as status 0..5
- Anim_Frame  out  3  frame index within row
- Flip  out  1  horizontal mirror for the sprite ROM
- Attack_Active  out  1  hitbox enable
- Anim_Done  out  1  one-cycle pulse on one-shot completion
- Busy  out  1  attack one-shot in progress

Behaviour:
- Interface: one clock (frame_clk). Reset is asynchronous and active-high.
- All outputs are registered.
- Reset values: Anim_Row=0, Anim_Frame=0, Flip=0, Attack_Active=0, Anim_Done=0, Busy=0. The internal tick counter is 0.
- Status mapping: input values 6..15 are treated as 0 (idle).
- Latency: an input sampled at edge N is reflected on the outputs after edge N.

Row change (Busy=0):
- If the mapped status differs from Anim_Row: load Anim_Row with it, Anim_Frame=0, tick=0.
- If mapped status is 4: also set Busy=1 and latch Flip from Inverse.

Frame advance (no row change):
- tick increments each cycle.
- At tick==TICKS_PER_FRAME-1: tick=0 and the frame advances according to the row's mode.
- Loop rows (0, 1, 3): the frame wraps from N-1 to 0.
- Hold rows (2, 5): the frame saturates at N-1 and tick keeps cycling.

Attack lock (Busy=1):
- All status inputs other than 5 are ignored. Flip is frozen.
- At the final tick of frame ATK_FRAMES-1, Anim_Done=1 for one cycle and:
  - if mapped status is 4: Anim_Frame=0, tick=0, Busy stays 1, and Flip is relatched;
  - otherwise: Busy=0, Anim_Row=mapped status, Anim_Frame=0, tick=0.
- Attack_Active=1 exactly while Anim_Row==4 and ATK_HIT_FIRST<=Anim_Frame<=ATK_HIT_LAST. It is 0 otherwise, including idle and dead.

Death preemption:
- Status 5 is accepted in any state, including Busy.
- On acceptance: Busy=0, Attack_Active=0, Anim_Row=5, Anim_Frame=0, tick=0, Flip=0.
- Anim_Done pulses once, on the cycle Anim_Frame becomes DEAD_FRAMES-1.
- If DEAD_FRAMES==1, Anim_Done pulses on the entry cycle.
- Leaving row 5 is only possible via status change (normal rule) or Reset.

Flip:
- When Busy=0 and Anim_Row≠5, Flip is registered from Inverse every cycle.

Simultaneous events:
- Status change on the same cycle as a frame-advance tick: the row change wins (frame=0).
- Reset mid-attack: everything returns to reset values immediately. No Anim_Done pulse is produced.

Widths:
- tick is 4 bits and frame is 3 bits.
- Comparisons use full width; no wrap beyond N-1 is permitted.

Test Plan:
1. Reset, status=0 held: Anim_Frame increments 0→1→2→3 every 6 cycles and returns to 0 at cycle 24. Attack_Active=0 and Anim_Done=0 throughout.
2. Status 0→1 mid-frame, Inverse=1: next edge gives Anim_Row=1, Anim_Frame=0, Flip=1. Walk wraps after frame 5 (36 cycles).
3. Status=4 for one cycle, then 0, Inverse toggles during the attack:
   - Anim_Row=4 and Busy=1 for 30 cycles, Flip held.
   - Attack_Active high during cycles 12..23.
   - Anim_Done pulses at cycle 30, together with Anim_Row=0, Anim_Frame=0, Busy=0.
4. Status=2 held 40 cycles: Anim_Frame goes 0,1,2 then stays 2. Then status=3: Anim_Row=3 and the 0/1 loop runs every 6 cycles.
5. Status=5 at attack frame 3: next edge gives Anim_Row=5, Busy=0, Attack_Active=0, Flip=0. Anim_Frame reaches 5 at cycle 30 with an Anim_Done pulse, then holds 5.
6. Status=9: behaves as idle (Anim_Row=0). Assert Reset during attack frame 2: all outputs are 0 asynchronously, with no Anim_Done pulse.

Source files
------------

// File: rtl/knight_anim_seq.sv
// Knight sprite animation sequencer: maps player status to sprite row/frame/flip,
// owns per-row frame timing, attack one-shot locking and the attack hit window.
module knight_anim_seq #(
  parameter int TICKS_PER_FRAME = 6,
  parameter int IDLE_FRAMES     = 4,
  parameter int WALK_FRAMES     = 6,
  parameter int JUMP_FRAMES     = 3,
  parameter int FALL_FRAMES     = 2,
  parameter int ATK_FRAMES      = 5,
  parameter int DEAD_FRAMES     = 6,
  parameter int ATK_HIT_FIRST   = 2,
  parameter int ATK_HIT_LAST    = 3
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [3:0] Player_Status,
  input  logic       Inverse,
  output logic [2:0] Anim_Row,
  output logic [2:0] Anim_Frame,
  output logic       Flip,
  output logic       Attack_Active,
  output logic       Anim_Done,
  output logic       Busy
);

  localparam logic [2:0] ROW_IDLE = 3'd0;
  localparam logic [2:0] ROW_WALK = 3'd1;
  localparam logic [2:0] ROW_JUMP = 3'd2;
  localparam logic [2:0] ROW_FALL = 3'd3;
  localparam logic [2:0] ROW_ATK  = 3'd4;
  localparam logic [2:0] ROW_DEAD = 3'd5;

  localparam logic [3:0] TICK_LAST = 4'(TICKS_PER_FRAME - 1);
  localparam logic [2:0] HIT_FIRST = 3'(ATK_HIT_FIRST);
  localparam logic [2:0] HIT_LAST  = 3'(ATK_HIT_LAST);
  localparam logic       DEAD_ONE  = (DEAD_FRAMES == 1) ? 1'b1 : 1'b0;

  typedef enum logic {
    MODE_FREE   = 1'b0,
    MODE_ATTACK = 1'b1
  } mode_t;

  mode_t      mode_r, mode_s;
  logic [2:0] row_r, row_s;
  logic [2:0] frame_r, frame_s;
  logic [3:0] tick_r, tick_s;
  logic       flip_r, flip_s;
  logic       atk_r, atk_s;
  logic       done_r, done_s;
  logic [2:0] status_s;
  logic [2:0] last_s;
  logic       tick_wrap_s;

  function automatic logic [2:0] map_status(input logic [3:0] st);
    if (st > 4'd5) begin
      return ROW_IDLE;
    end else begin
      return st[2:0];
    end
  endfunction

  function automatic logic [2:0] last_frame(input logic [2:0] row);
    case (row)
      ROW_IDLE: return 3'(IDLE_FRAMES - 1);
      ROW_WALK: return 3'(WALK_FRAMES - 1);
      ROW_JUMP: return 3'(JUMP_FRAMES - 1);
      ROW_FALL: return 3'(FALL_FRAMES - 1);
      ROW_ATK:  return 3'(ATK_FRAMES - 1);
      ROW_DEAD: return 3'(DEAD_FRAMES - 1);
      default:  return 3'd0;
    endcase
  endfunction

  function automatic logic is_hold_row(input logic [2:0] row);
    return (row == ROW_JUMP) || (row == ROW_DEAD);
  endfunction

  // Next-state: death preemption, attack lock, row change, then frame timing.
  always_comb begin
    mode_s      = mode_r;
    row_s       = row_r;
    frame_s     = frame_r;
    tick_s      = tick_r;
    flip_s      = flip_r;
    done_s      = 1'b0;
    status_s    = map_status(Player_Status);
    last_s      = last_frame(row_r);
    tick_wrap_s = (tick_r >= TICK_LAST);

    if ((status_s == ROW_DEAD) && (row_r != ROW_DEAD)) begin
      mode_s  = MODE_FREE;
      row_s   = ROW_DEAD;
      frame_s = 3'd0;
      tick_s  = 4'd0;
      flip_s  = 1'b0;
      done_s  = DEAD_ONE;
    end else if (mode_r == MODE_ATTACK) begin
      // Flip stays frozen for the whole swing unless it restarts
      if (tick_wrap_s) begin
        tick_s = 4'd0;
        if (frame_r >= last_s) begin
          done_s  = 1'b1;
          frame_s = 3'd0;
          if (status_s == ROW_ATK) begin
            flip_s = Inverse;
          end else begin
            mode_s = MODE_FREE;
            row_s  = status_s;
          end
        end else begin
          frame_s = frame_r + 3'd1;
        end
      end else begin
        tick_s = tick_r + 4'd1;
      end
    end else if (status_s != row_r) begin
      row_s   = status_s;
      frame_s = 3'd0;
      tick_s  = 4'd0;
      if (status_s == ROW_ATK) begin
        mode_s = MODE_ATTACK;
        flip_s = Inverse;
      end else if (row_r != ROW_DEAD) begin
        flip_s = Inverse;
      end else begin
        flip_s = flip_r;
      end
    end else begin
      if (row_r != ROW_DEAD) begin
        flip_s = Inverse;
      end else begin
        flip_s = flip_r;
      end
      if (tick_wrap_s) begin
        tick_s = 4'd0;
        if (frame_r < last_s) begin
          frame_s = frame_r + 3'd1;
          if ((row_r == ROW_DEAD) && ((frame_r + 3'd1) == last_s)) begin
            done_s = 1'b1;
          end else begin
            done_s = 1'b0;
          end
        end else if (is_hold_row(row_r)) begin
          frame_s = last_s;
        end else begin
          frame_s = 3'd0;
        end
      end else begin
        tick_s = tick_r + 4'd1;
      end
    end

    atk_s = (row_s == ROW_ATK) && (frame_s >= HIT_FIRST) && (frame_s <= HIT_LAST);
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      mode_r  <= MODE_FREE;
      row_r   <= 3'd0;
      frame_r <= 3'd0;
      tick_r  <= 4'd0;
      flip_r  <= 1'b0;
      atk_r   <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      mode_r  <= mode_s;
      row_r   <= row_s;
      frame_r <= frame_s;
      tick_r  <= tick_s;
      flip_r  <= flip_s;
      atk_r   <= atk_s;
      done_r  <= done_s;
    end
  end

  assign Anim_Row      = row_r;
  assign Anim_Frame    = frame_r;
  assign Flip          = flip_r;
  assign Attack_Active = atk_r;
  assign Anim_Done     = done_r;
  assign Busy          = (mode_r == MODE_ATTACK);

endmodule

// File: tb/tb_knight_anim_seq.sv
// Table-driven bench for knight_anim_seq: each record holds inputs for n cycles,
// then the queued expectation is popped and compared; reset corners are hand-written.
module tb_knight_anim_seq;

  logic       frame_clk;
  logic       Reset;
  logic [3:0] Player_Status;
  logic       Inverse;
  logic [2:0] Anim_Row;
  logic [2:0] Anim_Frame;
  logic       Flip;
  logic       Attack_Active;
  logic       Anim_Done;
  logic       Busy;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    logic [3:0] st;
    logic       inv;
    int         n;
    logic [2:0] row;
    logic [2:0] frame;
    logic       flip;
    logic       atk;
    logic       done;
    logic       busy;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];

  knight_anim_seq dut (
    .frame_clk     (frame_clk),
    .Reset         (Reset),
    .Player_Status (Player_Status),
    .Inverse       (Inverse),
    .Anim_Row      (Anim_Row),
    .Anim_Frame    (Anim_Frame),
    .Flip          (Flip),
    .Attack_Active (Attack_Active),
    .Anim_Done     (Anim_Done),
    .Busy          (Busy)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  function automatic vec_t mk(input int st, input int inv, input int n, input int row,
                              input int frame, input int flip, input int atk,
                              input int done, input int busy);
    vec_t v;
    v.st    = 4'(st);
    v.inv   = 1'(inv);
    v.n     = n;
    v.row   = 3'(row);
    v.frame = 3'(frame);
    v.flip  = 1'(flip);
    v.atk   = 1'(atk);
    v.done  = 1'(done);
    v.busy  = 1'(busy);
    return v;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_row"},   {5'd0, Anim_Row},   8'd0);
    chk({tag, "_frame"}, {5'd0, Anim_Frame}, 8'd0);
    chk({tag, "_flip"},  {7'd0, Flip},       8'd0);
    chk({tag, "_atk"},   {7'd0, Attack_Active}, 8'd0);
    chk({tag, "_done"},  {7'd0, Anim_Done},  8'd0);
    chk({tag, "_busy"},  {7'd0, Busy},       8'd0);
  endtask

  initial begin
    vec_t v;
    vec_t e;
    // idle loop
    vecs.push_back(mk(0,0,6,  0,1,0,0,0,0));
    vecs.push_back(mk(0,0,6,  0,2,0,0,0,0));
    vecs.push_back(mk(0,0,6,  0,3,0,0,0,0));
    vecs.push_back(mk(0,0,6,  0,0,0,0,0,0));
    vecs.push_back(mk(0,0,3,  0,0,0,0,0,0));
    // walk with left facing, mid-frame entry
    vecs.push_back(mk(1,1,1,  1,0,1,0,0,0));
    vecs.push_back(mk(1,1,30, 1,5,1,0,0,0));
    vecs.push_back(mk(1,1,6,  1,0,1,0,0,0));
    // one-cycle attack press, Inverse toggling during the swing
    vecs.push_back(mk(4,0,1,  4,0,0,0,0,1));
    vecs.push_back(mk(0,1,11, 4,1,0,0,0,1));
    vecs.push_back(mk(0,1,1,  4,2,0,1,0,1));
    vecs.push_back(mk(0,0,11, 4,3,0,1,0,1));
    vecs.push_back(mk(0,1,1,  4,4,0,0,0,1));
    vecs.push_back(mk(0,0,5,  4,4,0,0,0,1));
    vecs.push_back(mk(0,0,1,  0,0,0,0,1,0));
    vecs.push_back(mk(0,1,1,  0,0,1,0,0,0));
    // held attack restarts and relatches Flip
    vecs.push_back(mk(4,0,1,  4,0,0,0,0,1));
    vecs.push_back(mk(4,1,29, 4,4,0,0,0,1));
    vecs.push_back(mk(4,1,1,  4,0,1,0,1,1));
    vecs.push_back(mk(0,1,30, 0,0,1,0,1,0));
    // jump holds last frame, then fall loop
    vecs.push_back(mk(2,0,1,  2,0,0,0,0,0));
    vecs.push_back(mk(2,0,17, 2,2,0,0,0,0));
    vecs.push_back(mk(2,0,23, 2,2,0,0,0,0));
    vecs.push_back(mk(3,0,1,  3,0,0,0,0,0));
    vecs.push_back(mk(3,0,6,  3,1,0,0,0,0));
    vecs.push_back(mk(3,0,6,  3,0,0,0,0,0));
    // death preempts attack at frame 3
    vecs.push_back(mk(4,0,1,  4,0,0,0,0,1));
    vecs.push_back(mk(4,0,18, 4,3,0,1,0,1));
    vecs.push_back(mk(5,1,1,  5,0,0,0,0,0));
    vecs.push_back(mk(5,1,29, 5,4,0,0,0,0));
    vecs.push_back(mk(5,1,1,  5,5,0,0,1,0));
    vecs.push_back(mk(5,1,1,  5,5,0,0,0,0));
    vecs.push_back(mk(5,1,12, 5,5,0,0,0,0));
    // invalid status behaves as idle, then attack up to frame 2
    vecs.push_back(mk(9,0,1,  0,0,0,0,0,0));
    vecs.push_back(mk(9,1,1,  0,0,1,0,0,0));
    vecs.push_back(mk(4,0,1,  4,0,0,0,0,1));
    vecs.push_back(mk(0,0,12, 4,2,0,1,0,1));

    Reset = 1'b0;
    Player_Status = 4'd0;
    Inverse = 1'b0;
    #2 Reset = 1'b1;
    #1 chk_all_zero("reset");
    @(posedge frame_clk);
    @(posedge frame_clk);
    #1 Reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      Player_Status = v.st;
      Inverse = v.inv;
      exp_q.push_back(v);
      for (int c = 0; c < v.n; c++) begin
        @(posedge frame_clk);
        #1;
        if (c < v.n - 1) begin
          chk($sformatf("v%0d_c%0d_done_quiet", i, c), {7'd0, Anim_Done}, 8'd0);
        end
      end
      e = exp_q.pop_front();
      chk($sformatf("v%0d_row", i),   {5'd0, Anim_Row},      {5'd0, e.row});
      chk($sformatf("v%0d_frame", i), {5'd0, Anim_Frame},    {5'd0, e.frame});
      chk($sformatf("v%0d_flip", i),  {7'd0, Flip},          {7'd0, e.flip});
      chk($sformatf("v%0d_atk", i),   {7'd0, Attack_Active}, {7'd0, e.atk});
      chk($sformatf("v%0d_done", i),  {7'd0, Anim_Done},     {7'd0, e.done});
      chk($sformatf("v%0d_busy", i),  {7'd0, Busy},          {7'd0, e.busy});
    end

    // Reset asserted mid-cycle during attack frame 2 clears outputs without a clock
    #2 Reset = 1'b1;
    #1 chk_all_zero("midatk_reset");
    for (int c = 0; c < 2; c++) begin
      @(posedge frame_clk);
      #1 chk($sformatf("reset_hold_done_%0d", c), {7'd0, Anim_Done}, 8'd0);
    end
    Reset = 1'b0;
    Player_Status = 4'd0;
    Inverse = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge frame_clk);
      #1 chk($sformatf("post_reset_done_%0d", c), {7'd0, Anim_Done}, 8'd0);
    end
    chk("post_reset_row",   {5'd0, Anim_Row},   8'd0);
    chk("post_reset_frame", {5'd0, Anim_Frame}, 8'd1);
    chk("post_reset_busy",  {7'd0, Busy},       8'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
